imm_ext_stage: RTL

Parametrised, registered immediate-extension stage for the mycpu datapath, sitting between decode and execute. It widens an IMM_W-bit instruction immediate to DATA_W bits in one of five modes: sign, zero, upper-load, shift-amount and branch-offset. Results are buffered in a 2-entry valid/ready skid buffer, so decode and execute can stall independently. A synchronous flush input discards buffered entries on pipeline redirects.

---
 rtl/imm_ext_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: widens an instruction immediate in one of
// five modes and buffers results in a 2-entry valid/ready skid FIFO with flush.
module imm_ext_stage #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [2:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_illegal
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int PAD_W = DATA_W - IMM_W;

  localparam logic [2:0] MODE_SIGN   = 3'd0;
  localparam logic [2:0] MODE_ZERO   = 3'd1;
  localparam logic [2:0] MODE_LUI    = 3'd2;
  localparam logic [2:0] MODE_SHAMT  = 3'd3;
  localparam logic [2:0] MODE_BRANCH = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              illegal;
  } entry_t;

  logic [DATA_W-1:0] sign_val;
  logic [DATA_W-1:0] zero_val;
  logic [DATA_W-1:0] lui_val;
  logic [DATA_W-1:0] shamt_val;
  logic [DATA_W-1:0] branch_val;

  // Per-bit construction of every extension candidate.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ext
      if (gi < IMM_W) begin : g_low
        assign sign_val[gi] = in_imm[gi];
        assign zero_val[gi] = in_imm[gi];
      end else begin : g_high
        assign sign_val[gi] = in_imm[IMM_W-1];
        assign zero_val[gi] = 1'b0;
      end
      if (gi < PAD_W) begin : g_lui_pad
        assign lui_val[gi] = 1'b0;
      end else begin : g_lui_imm
        assign lui_val[gi] = in_imm[gi-PAD_W];
      end
      // Shift amounts narrower than the immediate ignore the upper bits.
      if (gi < SH_W && gi < IMM_W) begin : g_sh_imm
        assign shamt_val[gi] = in_imm[gi];
      end else begin : g_sh_pad
        assign shamt_val[gi] = 1'b0;
      end
    end
  endgenerate

  assign branch_val = {sign_val[DATA_W-3:0], 2'b00};

  entry_t new_entry;

  always_comb begin
    new_entry         = '0;
    new_entry.tag     = in_tag;
    new_entry.illegal = 1'b0;
    case (in_mode)
      MODE_SIGN:   new_entry.data = sign_val;
      MODE_ZERO:   new_entry.data = zero_val;
      MODE_LUI:    new_entry.data = lui_val;
      MODE_SHAMT:  new_entry.data = shamt_val;
      MODE_BRANCH: new_entry.data = branch_val;
      default:     new_entry.illegal = 1'b1;
    endcase
  end

  logic [1:0] count_reg, count_next;
  entry_t     head_reg, head_next;
  entry_t     tail_reg, tail_next;
  logic       push, pop;

  assign in_ready  = (count_reg < 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // Head is the output register; tail only fills while the head is stalled.
  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) head_next = new_entry;
          else                   tail_next = new_entry;
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          if (count_reg == 2'd2) head_next = tail_reg;
          count_next = count_reg - 2'd1;
        end
        2'b11: begin
          head_next = new_entry;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  assign out_data    = head_reg.data;
  assign out_tag     = head_reg.tag;
  assign out_illegal = head_reg.illegal;

endmodule
